// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared types: entry kinds, controller states,
// and the next-PC helper used for redirects.
package reorder_buffer_pkg;

  localparam int ROB_W   = 3;
  localparam int NON_DEP = 1 << ROB_W;

  typedef enum logic [1:0] {
    T_REG    = 2'd0,
    T_STORE  = 2'd1,
    T_BRANCH = 2'd2,
    T_JUMP   = 2'd3
  } rob_type_e;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } rob_state_e;

  function automatic logic [31:0] next_pc(
    input logic        taken,
    input logic [31:0] target,
    input logic [31:0] pc
  );
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit unit: allocates entries, collects CDB results,
// retires the head to the RF/store path and raises mispredict flushes.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int RoB_WIDTH = ROB_W
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 alloc_en,
  input  logic [1:0]           alloc_type,
  input  logic [4:0]           alloc_rd,
  input  logic [31:0]          alloc_pc,
  input  logic                 alloc_pred_taken,
  output logic [RoB_WIDTH-1:0] alloc_index,
  output logic                 full,
  input  logic                 wb_en,
  input  logic [RoB_WIDTH-1:0] wb_index,
  input  logic [31:0]          wb_value,
  input  logic                 wb_taken,
  input  logic [31:0]          wb_target,
  input  logic [RoB_WIDTH-1:0] q1_index,
  input  logic [RoB_WIDTH-1:0] q2_index,
  output logic                 q1_ready,
  output logic                 q2_ready,
  output logic [31:0]          q1_value,
  output logic [31:0]          q2_value,
  output logic                 RoB_update_en,
  output logic [4:0]           RoB_update_reg,
  output logic [RoB_WIDTH-1:0] RoB_update_index,
  output logic [31:0]          RoB_update_data,
  output logic                 store_commit_en,
  output logic                 flush_signal,
  output logic [31:0]          redirect_pc,
  output logic                 debug_en,
  output logic [31:0]          debug_commit_id
);

  localparam int RoB_SIZE = 1 << RoB_WIDTH;
  localparam int CW       = RoB_WIDTH + 1;

  logic        busy   [RoB_SIZE];
  logic        ready  [RoB_SIZE];
  rob_type_e   etype  [RoB_SIZE];
  logic [4:0]  rd     [RoB_SIZE];
  logic [31:0] pc     [RoB_SIZE];
  logic        pred   [RoB_SIZE];
  logic [31:0] value  [RoB_SIZE];
  logic        taken  [RoB_SIZE];
  logic [31:0] target [RoB_SIZE];

  logic [RoB_WIDTH-1:0] head;
  logic [RoB_WIDTH-1:0] tail;
  logic [CW-1:0]        count;
  rob_state_e           state;
  logic [31:0]          flush_pc;

  logic      head_fire;
  logic      alloc_fire;
  logic      wb_fire;
  logic      mispredict;
  logic      writes_rd;
  rob_type_e h_type;

  assign alloc_index = tail;
  assign full = (count == CW'(RoB_SIZE)) || (state == S_FLUSH);

  assign q1_ready = busy[q1_index] && ready[q1_index];
  assign q2_ready = busy[q2_index] && ready[q2_index];
  assign q1_value = q1_ready ? value[q1_index] : '0;
  assign q2_value = q2_ready ? value[q2_index] : '0;

  assign h_type     = etype[head];
  assign head_fire  = (state == S_RUN) && busy[head] && ready[head];
  assign alloc_fire = alloc_en && !full;
  assign wb_fire    = wb_en && busy[wb_index] && (state == S_RUN);
  assign writes_rd  = (h_type == T_REG || h_type == T_JUMP)
                      && (rd[head] != 5'd0);
  assign mispredict = (h_type == T_BRANCH || h_type == T_JUMP)
                      && (taken[head] != pred[head]);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RoB_SIZE; i++) begin
        busy[i]   <= 1'b0;
        ready[i]  <= 1'b0;
        etype[i]  <= T_REG;
        rd[i]     <= '0;
        pc[i]     <= '0;
        pred[i]   <= 1'b0;
        value[i]  <= '0;
        taken[i]  <= 1'b0;
        target[i] <= '0;
      end
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      state            <= S_RUN;
      flush_pc         <= '0;
      RoB_update_en    <= 1'b0;
      RoB_update_reg   <= '0;
      RoB_update_index <= '0;
      RoB_update_data  <= '0;
      store_commit_en  <= 1'b0;
      flush_signal     <= 1'b0;
      redirect_pc      <= '0;
      debug_en         <= 1'b0;
      debug_commit_id  <= '0;
    end else if (rdy_in) begin
      RoB_update_en   <= 1'b0;
      store_commit_en <= 1'b0;
      flush_signal    <= 1'b0;
      debug_en        <= 1'b0;
      if (state == S_FLUSH) begin
        for (int i = 0; i < RoB_SIZE; i++) begin
          busy[i]  <= 1'b0;
          ready[i] <= 1'b0;
        end
        flush_signal <= 1'b1;
        redirect_pc  <= flush_pc;
        head         <= '0;
        tail         <= '0;
        count        <= '0;
        state        <= S_RUN;
      end else begin
        if (wb_fire) begin
          ready[wb_index]  <= 1'b1;
          value[wb_index]  <= wb_value;
          taken[wb_index]  <= wb_taken;
          target[wb_index] <= wb_target;
        end
        if (head_fire) begin
          busy[head]      <= 1'b0;
          ready[head]     <= 1'b0;
          head            <= head + RoB_WIDTH'(1);
          debug_commit_id <= debug_commit_id + 32'd1;
          if (writes_rd) begin
            RoB_update_en    <= 1'b1;
            RoB_update_reg   <= rd[head];
            RoB_update_index <= head;
            RoB_update_data  <= value[head];
            debug_en         <= 1'b1;
          end
          if (h_type == T_STORE) begin
            store_commit_en <= 1'b1;
            debug_en        <= 1'b1;
          end
          // RF update goes out now; the flush follows next cycle
          if (mispredict) begin
            state    <= S_FLUSH;
            flush_pc <= next_pc(taken[head], target[head], pc[head]);
          end
        end
        if (alloc_fire) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          etype[tail] <= rob_type_e'(alloc_type);
          rd[tail]    <= alloc_rd;
          pc[tail]    <= alloc_pc;
          pred[tail]  <= alloc_pred_taken;
          tail        <= tail + RoB_WIDTH'(1);
        end
        unique case ({alloc_fire, head_fire})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int W = 3;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          alloc_en;
  logic [1:0]    alloc_type;
  logic [4:0]    alloc_rd;
  logic [31:0]   alloc_pc;
  logic          alloc_pred_taken;
  logic [W-1:0]  alloc_index;
  logic          full;
  logic          wb_en;
  logic [W-1:0]  wb_index;
  logic [31:0]   wb_value;
  logic          wb_taken;
  logic [31:0]   wb_target;
  logic [W-1:0]  q1_index;
  logic [W-1:0]  q2_index;
  logic          q1_ready;
  logic          q2_ready;
  logic [31:0]   q1_value;
  logic [31:0]   q2_value;
  logic          RoB_update_en;
  logic [4:0]    RoB_update_reg;
  logic [W-1:0]  RoB_update_index;
  logic [31:0]   RoB_update_data;
  logic          store_commit_en;
  logic          flush_signal;
  logic [31:0]   redirect_pc;
  logic          debug_en;
  logic [31:0]   debug_commit_id;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.RoB_WIDTH(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_en(alloc_en), .alloc_type(alloc_type),
    .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
    .alloc_pred_taken(alloc_pred_taken),
    .alloc_index(alloc_index), .full(full),
    .wb_en(wb_en), .wb_index(wb_index), .wb_value(wb_value),
    .wb_taken(wb_taken), .wb_target(wb_target),
    .q1_index(q1_index), .q2_index(q2_index),
    .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .RoB_update_en(RoB_update_en), .RoB_update_reg(RoB_update_reg),
    .RoB_update_index(RoB_update_index),
    .RoB_update_data(RoB_update_data),
    .store_commit_en(store_commit_en),
    .flush_signal(flush_signal), .redirect_pc(redirect_pc),
    .debug_en(debug_en), .debug_commit_id(debug_commit_id)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_en = 0; alloc_type = 0; alloc_rd = 0; alloc_pc = 0;
    alloc_pred_taken = 0; wb_en = 0; wb_index = 0; wb_value = 0;
    wb_taken = 0; wb_target = 0; q1_index = 0; q2_index = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rdy_in = 1;
    rst_in = 0;
    tick();
    tick();
    rst_in = 1;
  endtask

  task automatic do_alloc(input logic [1:0] t, input logic [4:0] r,
                          input logic [31:0] p, input logic pt);
    alloc_en = 1; alloc_type = t; alloc_rd = r;
    alloc_pc = p; alloc_pred_taken = pt;
    tick();
    alloc_en = 0;
  endtask

  task automatic do_wb(input logic [W-1:0] i, input logic [31:0] v,
                       input logic tk, input logic [31:0] tg);
    wb_en = 1; wb_index = i; wb_value = v;
    wb_taken = tk; wb_target = tg;
    tick();
    wb_en = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rdy_in = 1;
    rst_in = 0;
    #1;
    tests++;
    if ({RoB_update_en, store_commit_en, flush_signal, debug_en, full}
        !== 5'b0 || debug_commit_id !== 0 || alloc_index !== 0) begin
      fails++;
      $display("FAIL reset_state: upd=%b st=%b fl=%b full=%b id=%0d idx=%0d, want all 0",
               RoB_update_en, store_commit_en, flush_signal, full,
               debug_commit_id, alloc_index);
    end
    tick();
    rst_in = 1;
  endtask

  task automatic test_reg_commit();
    apply_reset();
    do_alloc(T_REG, 5'd5, 32'h0, 1'b0);
    tests++;
    if (alloc_index !== 3'd1) begin
      fails++;
      $display("FAIL alloc_tail: got %0d want 1", alloc_index);
    end
    do_wb(3'd0, 32'h1234, 1'b0, 32'h0);
    q1_index = 0; q2_index = 1;
    #0;
    tests++;
    if (q1_ready !== 1 || q1_value !== 32'h1234 ||
        q2_ready !== 0 || q2_value !== 0) begin
      fails++;
      $display("FAIL bypass: q1=%b/%h q2=%b/%h want 1/1234 0/0",
               q1_ready, q1_value, q2_ready, q2_value);
    end
    tick();
    tests++;
    if (RoB_update_en !== 1 || RoB_update_reg !== 5 ||
        RoB_update_index !== 0 || RoB_update_data !== 32'h1234 ||
        debug_commit_id !== 1 || debug_en !== 1) begin
      fails++;
      $display("FAIL reg_commit: en=%b reg=%0d idx=%0d data=%h id=%0d, want 1 5 0 1234 1",
               RoB_update_en, RoB_update_reg, RoB_update_index,
               RoB_update_data, debug_commit_id);
    end
    tick();
    tests++;
    if (RoB_update_en !== 0 || debug_en !== 0) begin
      fails++;
      $display("FAIL reg_pulse_end: en=%b dbg=%b want 0 0",
               RoB_update_en, debug_en);
    end
  endtask

  task automatic test_full_in_order();
    logic early;
    logic ok;
    apply_reset();
    for (int i = 0; i < 8; i++)
      do_alloc(T_REG, 5'(i + 1), 32'h1000 + 32'(4 * i), 1'b0);
    tests++;
    if (full !== 1 || alloc_index !== 0) begin
      fails++;
      $display("FAIL full_after_8: full=%b idx=%0d want 1 0",
               full, alloc_index);
    end
    do_alloc(T_REG, 5'd31, 32'h2000, 1'b0);
    tests++;
    if (full !== 1 || alloc_index !== 0) begin
      fails++;
      $display("FAIL ninth_alloc: full=%b idx=%0d want 1 0",
               full, alloc_index);
    end
    early = 0;
    for (int i = 7; i >= 0; i--) begin
      do_wb(3'(i), 32'h100 + 32'(i), 1'b0, 32'h0);
      early = early | RoB_update_en;
    end
    tests++;
    if (early !== 0) begin
      fails++;
      $display("FAIL ooo_early_commit: got %b want 0", early);
    end
    ok = 1;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        alloc_en = 1; alloc_type = T_REG; alloc_rd = 5'd30;
      end
      tick();
      alloc_en = 0;
      if (RoB_update_en !== 1 || RoB_update_index !== 3'(k) ||
          RoB_update_reg !== 5'(k + 1) ||
          RoB_update_data !== 32'h100 + 32'(k)) begin
        ok = 0;
        $display("FAIL in_order_%0d: en=%b idx=%0d reg=%0d data=%h want 1 %0d %0d %h",
                 k, RoB_update_en, RoB_update_index, RoB_update_reg,
                 RoB_update_data, k, k + 1, 32'h100 + 32'(k));
      end
      if (k == 0) begin
        tests++;
        if (alloc_index !== 0) begin
          fails++;
          $display("FAIL full_commit_alloc: idx=%0d want 0", alloc_index);
        end
      end
    end
    tests++;
    if (!ok) fails++;
    tick();
    tests++;
    if (RoB_update_en !== 0 || full !== 0 ||
        debug_commit_id !== 8 || alloc_index !== 0) begin
      fails++;
      $display("FAIL drain: en=%b full=%b id=%0d idx=%0d want 0 0 8 0",
               RoB_update_en, full, debug_commit_id, alloc_index);
    end
  endtask

  task automatic test_branch_flush();
    apply_reset();
    do_alloc(T_BRANCH, 5'd0, 32'h100, 1'b0);
    do_alloc(T_REG, 5'd3, 32'h104, 1'b0);
    do_wb(3'd1, 32'h55, 1'b0, 32'h0);
    do_wb(3'd0, 32'h0, 1'b1, 32'h200);
    tick();
    tests++;
    if (flush_signal !== 0 || full !== 1 || RoB_update_en !== 0) begin
      fails++;
      $display("FAIL branch_commit: fl=%b full=%b upd=%b want 0 1 0",
               flush_signal, full, RoB_update_en);
    end
    tick();
    tests++;
    if (flush_signal !== 1 || redirect_pc !== 32'h200 ||
        full !== 0 || alloc_index !== 0) begin
      fails++;
      $display("FAIL branch_flush: fl=%b pc=%h full=%b idx=%0d want 1 200 0 0",
               flush_signal, redirect_pc, full, alloc_index);
    end
    q1_index = 1;
    tick();
    tests++;
    if (flush_signal !== 0 || RoB_update_en !== 0 ||
        q1_ready !== 0 || debug_commit_id !== 1) begin
      fails++;
      $display("FAIL after_flush: fl=%b upd=%b q1=%b id=%0d want 0 0 0 1",
               flush_signal, RoB_update_en, q1_ready, debug_commit_id);
    end
  endtask

  task automatic test_jump_mispredict();
    apply_reset();
    do_alloc(T_JUMP, 5'd1, 32'h100, 1'b0);
    do_wb(3'd0, 32'h104, 1'b1, 32'h300);
    tick();
    tests++;
    if (RoB_update_en !== 1 || RoB_update_reg !== 1 ||
        RoB_update_data !== 32'h104 || flush_signal !== 0) begin
      fails++;
      $display("FAIL jump_update: en=%b reg=%0d data=%h fl=%b want 1 1 104 0",
               RoB_update_en, RoB_update_reg, RoB_update_data, flush_signal);
    end
    tick();
    tests++;
    if (flush_signal !== 1 || redirect_pc !== 32'h300 ||
        RoB_update_en !== 0) begin
      fails++;
      $display("FAIL jump_flush: fl=%b pc=%h upd=%b want 1 300 0",
               flush_signal, redirect_pc, RoB_update_en);
    end
  endtask

  task automatic test_store_and_nonbusy_wb();
    apply_reset();
    do_wb(3'd3, 32'hdead, 1'b0, 32'h0);
    q1_index = 3;
    #0;
    tests++;
    if (q1_ready !== 0 || q1_value !== 0) begin
      fails++;
      $display("FAIL nonbusy_wb: q1=%b/%h want 0/0", q1_ready, q1_value);
    end
    do_alloc(T_STORE, 5'd0, 32'h40, 1'b0);
    do_wb(3'd0, 32'h0, 1'b0, 32'h0);
    tick();
    tests++;
    if (store_commit_en !== 1 || RoB_update_en !== 0 ||
        debug_en !== 1 || debug_commit_id !== 1) begin
      fails++;
      $display("FAIL store_commit: st=%b upd=%b dbg=%b id=%0d want 1 0 1 1",
               store_commit_en, RoB_update_en, debug_en, debug_commit_id);
    end
  endtask

  task automatic test_rdy_hold();
    logic held;
    apply_reset();
    do_alloc(T_REG, 5'd7, 32'h0, 1'b0);
    do_wb(3'd0, 32'habc, 1'b0, 32'h0);
    tick();
    rdy_in = 0;
    held = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (RoB_update_en !== 1 || RoB_update_data !== 32'habc ||
          debug_commit_id !== 1) held = 0;
    end
    tests++;
    if (!held) begin
      fails++;
      $display("FAIL rdy_hold: en=%b data=%h id=%0d want 1 abc 1",
               RoB_update_en, RoB_update_data, debug_commit_id);
    end
    rdy_in = 1;
    tick();
    tests++;
    if (RoB_update_en !== 0 || debug_commit_id !== 1) begin
      fails++;
      $display("FAIL rdy_release: en=%b id=%0d want 0 1",
               RoB_update_en, debug_commit_id);
    end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    do_alloc(T_REG, 5'd1, 32'h0, 1'b0);
    do_alloc(T_REG, 5'd2, 32'h4, 1'b0);
    do_alloc(T_REG, 5'd3, 32'h8, 1'b0);
    do_wb(3'd0, 32'h11, 1'b0, 32'h0);
    #2;
    rst_in = 0;
    #1;
    q1_index = 1;
    #0;
    tests++;
    if (full !== 0 || alloc_index !== 0 || RoB_update_en !== 0 ||
        debug_commit_id !== 0 || q1_ready !== 0) begin
      fails++;
      $display("FAIL reset_mid: full=%b idx=%0d upd=%b id=%0d q1=%b want 0 0 0 0 0",
               full, alloc_index, RoB_update_en, debug_commit_id, q1_ready);
    end
    tick();
    rst_in = 1;
  endtask

  initial begin
    test_reset();
    test_reg_commit();
    test_full_in_order();
    test_branch_flush();
    test_jump_mispredict();
    test_store_and_nonbusy_wb();
    test_rdy_hold();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
